// File: rtl/types_pkg.sv
// Shared types for the instruction-fetch stage: word type, decode-stage
// payload and the fetch FSM state encoding.
package types;

  typedef logic [31:0] u32_t;

  // Payload handed to the decode stage: instruction word and its
  // fall-through address (fetch address + 4).
  typedef struct packed {
    u32_t ir;
    u32_t ia_plus_4;
  } id_params_t;

  // FETCH : free to issue a request
  // WAIT  : one request outstanding, its response is wanted
  // DROP  : one request outstanding, its response is stale and discarded
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

  localparam u32_t INSN_BYTES = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between fetch and decode. Power-of-two depth,
// simultaneous push/pop, and a flush that empties it in one cycle.
module fetch_fifo import types::*; #(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  id_params_t push_data,
  input  logic       pop,
  output id_params_t head,
  output logic [CW-1:0] count
);

  id_params_t    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  // Flush wins over both ends; a push into a full buffer is only legal
  // when the head leaves in the same cycle.
  always_comb begin
    do_pop  = pop && (count != '0) && !flush;
    do_push = push && !flush && ((count != CW'(DEPTH)) || do_pop);
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage.
  // NOTE: the data array has no reset; validity is tracked by count alone,
  // so resetting it would only cost flops and reset routing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding memory request FSM, program
// counter with redirect, and an instruction buffer towards decode.
module if_stage import types::*; #(
  parameter u32_t RESET_VECTOR = 32'h0000_0000,
  parameter int   FIFO_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        id_valid,
  input  logic        id_ready,
  output id_params_t  id_params
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  state;
  fetch_state_e  state_next;
  u32_t          pc;
  u32_t          pc_next;
  u32_t          req_addr;
  u32_t          req_addr_next;
  logic [CW-1:0] fifo_count;
  logic          accept;
  logic          push;
  logic          flush;
  logic          pop;
  id_params_t    push_data;

  // Next-state, request and buffer-control logic.
  // NOTE: every output of this block gets a default first so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    req_addr_next = req_addr;
    push          = 1'b0;
    flush         = redirect_valid;
    push_data     = '{ir: imem_rsp_data, ia_plus_4: req_addr + INSN_BYTES};

    // Issue only with a free buffer slot; in FETCH nothing is outstanding,
    // so count + outstanding can never exceed the depth.
    imem_req_valid = !rst && (state == FETCH) && (fifo_count < CW'(FIFO_DEPTH));
    imem_addr      = pc;
    accept         = imem_req_valid && imem_req_ready;

    case (state)
      FETCH: begin
        if (accept) begin
          req_addr_next = pc;
          pc_next       = pc + INSN_BYTES;
          // A request accepted together with a redirect is already stale.
          state_next    = redirect_valid ? DROP : WAIT;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          push       = !redirect_valid;
          state_next = FETCH;
        end else if (redirect_valid) begin
          state_next = DROP;
        end
      end
      DROP: begin
        if (imem_rsp_valid) state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase

    // Redirect overrides any sequential pc update.
    if (redirect_valid) pc_next = {redirect_addr[31:2], 2'b00};
  end

  // Fetch FSM, program counter and in-flight request address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= {RESET_VECTOR[31:2], 2'b00};
      req_addr <= '0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      req_addr <= req_addr_next;
    end
  end

  assign id_valid = (fifo_count != '0);
  assign pop      = id_valid && id_ready;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (id_params),
    .count     (fifo_count)
  );

endmodule
